uart8250_bus_bridge: RTL

- Upstream adapter between the core's MMIO valid/ready request/response bus and the simulation 8250 UART register port.
- Converts one bus access into a single-cycle register read or write strobe, then returns a bus response.
- One transaction outstanding at a time.
- For reads, it waits the one-cycle registered read latency of the UART before capturing the data byte.

---
 rtl/uart8250_bus_bridge.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart8250_bus_bridge.sv
// MMIO valid/ready bus to 8250 UART register-port bridge, one access in flight.
// Optional UART_BRIDGE_ERR_EN: reject requests whose req_be is not one-hot or misses the addressed lane.
module uart8250_bus_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int REG_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  u_rvalid,
    output logic [2:0]            u_raddr,
    input  logic [7:0]            u_rdata,
    output logic                  u_wvalid,
    output logic [2:0]            u_waddr,
    output logic [7:0]            u_wdata
);

    // state | meaning
    // IDLE  | ready for a request
    // WR    | UART write strobe is on the port
    // RD    | UART read strobe is on the port
    // RWAIT | UART read data arrives this cycle, captured at its end
    // RESP  | response held until rsp_ready
    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RESP} state_t;

    localparam int LANE_W = $clog2(DATA_W/8);

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                u_rvalid_q, u_rvalid_d;
    logic [2:0]          u_raddr_q, u_raddr_d;
    logic                u_wvalid_q, u_wvalid_d;
    logic [2:0]          u_waddr_q, u_waddr_d;
    logic [7:0]          u_wdata_q, u_wdata_d;

    logic [2:0]          req_idx;
    logic [LANE_W-1:0]   req_lane;
    logic [7:0]          req_wbyte;
    logic                req_bad;
    logic                unused_in;

    assign req_idx   = req_addr[REG_SHIFT+2:REG_SHIFT];
    assign req_lane  = req_addr[LANE_W-1:0];
    assign req_wbyte = req_wdata[{req_lane, 3'b000} +: 8];
    assign unused_in = ^{req_addr, req_be};

`ifdef UART_BRIDGE_ERR_EN
    assign req_bad = !$onehot(req_be) || !req_be[req_lane];
`else
    assign req_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        u_rvalid_d  = 1'b0;
        u_raddr_d   = u_raddr_q;
        u_wvalid_d  = 1'b0;
        u_waddr_d   = u_waddr_q;
        u_wdata_d   = u_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (req_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (req_we) begin
                        state_d    = WR;
                        u_wvalid_d = 1'b1;
                        u_waddr_d  = req_idx;
                        u_wdata_d  = req_wbyte;
                    end else begin
                        state_d    = RD;
                        u_rvalid_d = 1'b1;
                        u_raddr_d  = req_idx;
                        lane_d     = req_lane;
                    end
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            RD: state_d = RWAIT;
            RWAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = DATA_W'(u_rdata) << {lane_q, 3'b000};
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            u_rvalid_q  <= 1'b0;
            u_raddr_q   <= '0;
            u_wvalid_q  <= 1'b0;
            u_waddr_q   <= '0;
            u_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            u_rvalid_q  <= u_rvalid_d;
            u_raddr_q   <= u_raddr_d;
            u_wvalid_q  <= u_wvalid_d;
            u_waddr_q   <= u_waddr_d;
            u_wdata_q   <= u_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign u_rvalid  = u_rvalid_q;
    assign u_raddr   = u_raddr_q;
    assign u_wvalid  = u_wvalid_q;
    assign u_waddr   = u_waddr_q;
    assign u_wdata   = u_wdata_q;

endmodule
